// File: rtl/socket_pkg.sv
// rtl/socket_pkg.sv - shared types and width helper for the socket write arbiter
package socket_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

  // Width helper that never returns zero, so 1-entry counters still get a bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational first-set search starting at a rotating pointer
module rr_picker
  import socket_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [PTR_W-1:0]   o_idx
);

  // Explicit wrap so non-power-of-two NUM_REQ never indexes past the top.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int off);
    int k;
    k = int'(p) + off;
    if (k >= NUM_REQ) k = k - NUM_REQ;
    return k[PTR_W-1:0];
  endfunction

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!o_found && i_req[wrap_idx(i_ptr, off)]) begin
        o_found = 1'b1;
        o_idx   = wrap_idx(i_ptr, off);
      end
    end
  end

endmodule

// File: rtl/socket_wr_arbiter.sv
// rtl/socket_wr_arbiter.sv - round-robin burst arbiter feeding one socket FIFO write port
module socket_wr_arbiter
  import socket_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          i_full,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int PTR_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(BURST_LEN + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;

  logic             w_found;
  logic [PTR_W-1:0] w_pick_idx;
  logic             w_in_grant;
  logic             w_gnt_valid;
  logic             w_xfer;
  logic             w_last;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req   (i_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_gnt_valid = i_valid[r_gnt_id];
  assign w_xfer      = w_in_grant & w_gnt_valid & ~i_full;
  assign w_last      = (r_burst_cnt == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gnt_id_nxt    = r_gnt_id;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_id_nxt = w_pick_idx;
        end
      end
      ST_GRANT: begin
        // A dropped valid releases even with zero words moved; a full socket only stalls.
        if (!w_gnt_valid || (w_xfer && w_last)) begin
          w_state_nxt     = ST_IDLE;
          w_burst_cnt_nxt = '0;
          w_rr_ptr_nxt    = (r_gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + PTR_W'(1);
        end else if (w_xfer) begin
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_grant = '0;
    o_ready = '0;
    o_data  = '0;
    o_busy  = w_in_grant;
    o_wr_en = w_xfer;
    if (w_in_grant) begin
      o_grant = NUM_REQ'(1) << r_gnt_id;
      o_ready = i_full ? '0 : (NUM_REQ'(1) << r_gnt_id);
      o_data  = i_data[int'(r_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: doc/socket_wr_arbiter.md
Name: socket_wr_arbiter

Overview:
Round-robin write arbiter that shares one socket FIFO between NUM_REQ producer tasks. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the socket's i_wr_en/i_data from the granted stream. It respects the socket's o_full so the FIFO is never overrun. It sits directly upstream of a socket instance; its o_wr_en/o_data connect to the socket's i_wr_en/i_data, and the socket's o_full connects to i_full.

Parameters:
DATA_WIDTH, 8, width of each data word; must equal the socket DATA_WIDTH
NUM_REQ, 4, number of producers; minimum 2
BURST_LEN, 4, maximum words transferred per grant before forced release; minimum 1

Ports:
i_clk  input  1  clock, all state updates on the rising edge
i_rst  input  1  asynchronous, active-low reset
i_valid  input  NUM_REQ  per-producer valid; bit k belongs to producer k
i_data  input  NUM_REQ*DATA_WIDTH  producer k's word is in bits [k*DATA_WIDTH +: DATA_WIDTH]
o_ready  output  NUM_REQ  per-producer ready; a word transfers on a cycle where valid[k] and ready[k] are both high
i_full  input  1  socket full flag
o_wr_en  output  1  socket write enable
o_data  output  DATA_WIDTH  socket write data
o_grant  output  NUM_REQ  one-hot current grant; all zero when idle
o_busy  output  1  high while in GRANT

Behaviour:
- Reset (i_rst low, asynchronous assert, synchronous-to-clock release):
  - state=IDLE, rr_ptr=0, burst_cnt=0, gnt_id=0.
  - o_grant=0, o_busy=0, o_ready=0, o_wr_en=0, o_data=0.
  - A reset in the middle of a burst abandons it immediately; a word is never half-written because writes are single-cycle.
- Internal state:
  - rr_ptr: $clog2(NUM_REQ) bits.
  - gnt_id: $clog2(NUM_REQ) bits.
  - burst_cnt: $clog2(BURST_LEN+1) bits.
- IDLE:
  - If any i_valid bit is high, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register it into gnt_id and go to GRANT on the next edge.
  - Grant latency is 1 cycle: valid sampled at cycle N gives the first possible transfer at cycle N+1.
  - o_ready=0 and o_wr_en=0 throughout IDLE.
- GRANT:
  - o_grant=onehot(gnt_id) and o_busy=1.
  - o_ready[gnt_id] = ~i_full. All other o_ready bits are 0.
  - o_wr_en = i_valid[gnt_id] & ~i_full. This is combinational, so a write always coincides with its handshake.
  - o_data = i_data slice gnt_id, combinational. In IDLE o_data is 0.
  - On each transfer, burst_cnt increments.
- Release from GRANT to IDLE, on the clock edge after either condition:
  - (a) a transfer occurs while burst_cnt == BURST_LEN-1, i.e. the last word of the burst; or
  - (b) i_valid[gnt_id] is low. A producer dropping valid ends its burst even at 0 words.
- On release: rr_ptr = (gnt_id+1) mod NUM_REQ and burst_cnt=0.
- Every grant is followed by one IDLE bubble cycle. This is by design.
- i_full high in GRANT:
  - Stall: no transfer, burst_cnt holds, grant held.
  - There is no timeout. Release condition (b) still applies if the producer drops valid.
- Producer contract: data must be held stable while valid is high and ready is low. The arbiter does not check this.
- Simultaneous requests are resolved only by rotating priority; after reset producer 0 has highest priority.
- NUM_REQ not a power of 2: the rr_ptr increment wraps explicitly at NUM_REQ-1 to 0.
- BURST_LEN=1: release after every word.

Decomposition:
- socket_pkg holds:
  - typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;
  - the helper function clog2_min1(n), which returns max(1, $clog2(n)) for counter and pointer widths.
- One sub-module, rr_picker: purely combinational.
  - Inputs: req[NUM_REQ] and ptr.
  - Outputs: found and idx (the first set req bit at or above ptr, wrapping).
- The FSM, counters and output muxing stay in socket_wr_arbiter.

Test Plan:
- Single producer: NUM_REQ=4, BURST_LEN=4, i_full=0. i_valid=0001 at cycle 0 holding words A,B, valid dropped after B → o_grant=0001 from cycle 1; o_wr_en high at cycles 1-2 with o_data A,B; release; rr_ptr=1.
- All four producers continuously valid, i_full=0 → grants 0,1,2,3,0 in order; each grant gives exactly 4 writes followed by 1 idle cycle; 20 writes over 25 cycles.
- Producer 2 bursting while i_full is forced high for 3 cycles after word 2 → o_ready[2]=0 and o_wr_en=0 for those 3 cycles; o_grant stays 0100; burst_cnt stays 2; words 3-4 complete afterwards.
- Producers 1 and 3 valid, producer 1 drops valid after 2 words → release after 2 writes; next grant is producer 3 (rr_ptr=2 search).
- i_rst pulled low asynchronously mid-burst between clock edges → all outputs 0 immediately. After release with i_valid=1111, producer 0 is granted first.
- Integration with a socket (DEPTH=4, reader idle), producer 0 offering 6 words, BURST_LEN=8 → exactly 4 writes, socket o_full=1, producer stalls. After 2 reads, the remaining 2 words are written and the FIFO contents match in order.
